sw_en_poller: RTL and testbench
===============================

SW_EN_POLLER -- requirements
Module: system_sw_en_poller

Interface
REQ-001 Parameter PERIOD_RST, default 1000: reset value of PERIOD register, in clk cycles between polls.
REQ-002 Parameter DEB_N, default 4, range 1-15: consecutive equal samples required to accept a new level.
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset; no other clock or reset exists.
REQ-005 m_address  out  2  Avalon-MM master address to the switch-enable PIO; constant 0.
REQ-006 m_read  out  1  master read strobe.
REQ-007 m_waitrequest  in  1  PIO stall; transfer completes on a cycle with m_read=1 and m_waitrequest=0.
REQ-008 m_readdata  in  32  PIO read data; only bit 0 used, bits 31:1 ignored.
REQ-009 address  in  2  CSR slave word address.
REQ-010 chipselect  in  1  CSR select.
REQ-011 write_n  in  1  CSR write, active-low, qualified by chipselect.
REQ-012 writedata  in  32  CSR write data.
REQ-013 readdata  out  32  CSR read data, registered, 1-cycle latency, unused bits 0.
REQ-014 sw_en  out  1  debounced switch level.
REQ-015 irq  out  1  level interrupt.

Function
REQ-016 CSR map: 0 CTRL (bit0 EN, bit1 IE, R/W); 1 PERIOD (bits15:0, R/W); 2 STATUS (bit0 = sw_en, bit1 EDGE, write 1 to bit1 clears EDGE); 3 POLLS (bits15:0 completed-poll count, RO, writes ignored).
REQ-017 readdata SHALL be updated every cycle with the word selected by address, regardless of chipselect.
REQ-018 FSM states: IDLE, WAIT, READ, EVAL.
REQ-019 IDLE -> WAIT when EN=1; in WAIT, the countdown SHALL load PERIOD on entry.
REQ-020 WAIT: decrement the countdown each cycle; when it reaches 0, go to READ; PERIOD=0 SHALL behave as 1.
REQ-021 READ: m_read=1 and m_address=0, held stable until m_waitrequest=0; on that cycle, capture m_readdata[0] into the sample register and go to EVAL.
REQ-022 EVAL (1 cycle): run the debounce update, increment POLLS (16-bit wrap 0xFFFF->0), then go to WAIT if EN=1, else to IDLE.
REQ-023 m_read SHALL be 0 in every state except READ.
REQ-024 Debounce: if sample equals sw_en, clear the match counter; otherwise increment it, and when it reaches DEB_N set sw_en to sample, clear the counter and set EDGE.
REQ-025 Clearing EN in WAIT SHALL return the FSM to IDLE next cycle; clearing EN in READ SHALL NOT abort the transfer, which completes through EVAL and then enters IDLE.
REQ-026 A PERIOD write SHALL take effect at the next WAIT entry.
REQ-027 irq = EDGE AND IE, combinational from registers.
REQ-028 If an EDGE set and a STATUS write-1-clear occur in the same cycle, set SHALL win.

Reset
REQ-029 While reset_n=0: FSM in IDLE; m_read=0; m_address=0; readdata=0; CTRL=0; PERIOD=PERIOD_RST; sw_en=0; EDGE=0; POLLS=0; match counter=0; irq=0.
REQ-030 An assertion of reset_n during READ SHALL drop m_read asynchronously; the pending transfer is abandoned.

Verification
REQ-031 PERIOD=3, EN=1, m_waitrequest=0, PIO bit0=1, DEB_N=4 -> m_read pulses every 5 cycles (3 WAIT + READ + EVAL); sw_en rises after the 4th poll; EDGE=1.
REQ-032 IE=1, sw_en toggles -> irq=1; write STATUS=0x2 -> irq=0 on the next cycle.
REQ-033 PIO bit0 pattern 1,1,0,1,1,1,1 with sw_en=0 -> sw_en rises only after the 7th poll.
REQ-034 m_waitrequest held high for 10 cycles in READ -> m_read and m_address stable for 11 cycles; single POLLS increment.
REQ-035 EN cleared during READ -> transfer completes, POLLS +1, FSM enters IDLE, no further m_read.
REQ-036 POLLS preloaded by 65535 polls -> the next poll reads back 0; reset_n pulsed mid-READ -> all REQ-029 values.

Source files
------------

// File: rtl/sw_en_poller.sv
// Periodic poller for the switch-enable PIO bit. It debounces the bit, counts
// completed polls and raises a level interrupt on each accepted edge.
//
// state | meaning
// IDLE  | polling disabled, waiting for EN
// WAIT  | counting down PERIOD cycles before the next poll
// READ  | Avalon-MM read of the PIO in flight
// EVAL  | debounce update and poll count, one cycle
module sw_en_poller #(
  parameter int unsigned PERIOD_RST = 1000,
  parameter int unsigned DEB_N      = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [1:0]  m_address,
  output logic        m_read,
  input  logic        m_waitrequest,
  input  logic [31:0] m_readdata,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        sw_en,
  output logic        irq
);

  localparam logic [15:0] PERIOD_INIT = 16'(PERIOD_RST);
  localparam logic [3:0]  DEB_LIM     = 4'(DEB_N);

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_PERIOD = 2'd1;
  localparam logic [1:0] A_STATUS = 2'd2;
  localparam logic [1:0] A_POLLS  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_READ = 2'd2,
    ST_EVAL = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        en_q, en_d;
  logic        ie_q, ie_d;
  logic [15:0] period_q, period_d;
  logic        sw_q, sw_d;
  logic        edge_q, edge_d;
  logic [15:0] polls_q, polls_d;
  logic [3:0]  match_q, match_d;
  logic        sample_q, sample_d;
  logic [31:0] readdata_q, readdata_d;

  logic        edge_set;
  logic        csr_wr;
  logic [15:0] load_val;
  logic [3:0]  match_inc;
  logic        unused_bits;

  assign unused_bits = ^{m_readdata[31:1], writedata[31:16], writedata[15:2]};

  assign csr_wr    = chipselect & ~write_n;
  // A zero PERIOD still spends one cycle in WAIT.
  assign load_val  = (period_q == 16'd0) ? 16'd1 : period_q;
  assign match_inc = match_q + 4'd1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sample_d = sample_q;
    sw_d     = sw_q;
    match_d  = match_q;
    polls_d  = polls_q;
    edge_set = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (en_q) begin
          state_d = ST_WAIT;
          cnt_d   = load_val;
        end
      end
      ST_WAIT: begin
        if (!en_q) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 16'd1;
          if (cnt_q == 16'd1) state_d = ST_READ;
        end
      end
      ST_READ: begin
        if (!m_waitrequest) begin
          sample_d = m_readdata[0];
          state_d  = ST_EVAL;
        end
      end
      ST_EVAL: begin
        polls_d = polls_q + 16'd1;
        if (sample_q == sw_q) begin
          match_d = 4'd0;
        end else if (match_inc == DEB_LIM) begin
          sw_d     = sample_q;
          match_d  = 4'd0;
          edge_set = 1'b1;
        end else begin
          match_d = match_inc;
        end
        if (en_q) begin
          state_d = ST_WAIT;
          cnt_d   = load_val;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    en_d     = en_q;
    ie_d     = ie_q;
    period_d = period_q;
    edge_d   = edge_q;
    if (csr_wr) begin
      unique case (address)
        A_CTRL: begin
          en_d = writedata[0];
          ie_d = writedata[1];
        end
        A_PERIOD: period_d = writedata[15:0];
        A_STATUS: if (writedata[1]) edge_d = 1'b0;
        default: ;
      endcase
    end
    // A new edge overrides a same-cycle clear.
    if (edge_set) edge_d = 1'b1;
  end

  always_comb begin
    readdata_d = 32'd0;
    unique case (address)
      A_CTRL:   readdata_d = {30'd0, ie_q, en_q};
      A_PERIOD: readdata_d = {16'd0, period_q};
      A_STATUS: readdata_d = {30'd0, edge_q, sw_q};
      A_POLLS:  readdata_d = {16'd0, polls_q};
      default:  readdata_d = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 16'd0;
      en_q       <= 1'b0;
      ie_q       <= 1'b0;
      period_q   <= PERIOD_INIT;
      sw_q       <= 1'b0;
      edge_q     <= 1'b0;
      polls_q    <= 16'd0;
      match_q    <= 4'd0;
      sample_q   <= 1'b0;
      readdata_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      en_q       <= en_d;
      ie_q       <= ie_d;
      period_q   <= period_d;
      sw_q       <= sw_d;
      edge_q     <= edge_d;
      polls_q    <= polls_d;
      match_q    <= match_d;
      sample_q   <= sample_d;
      readdata_q <= readdata_d;
    end
  end

  // m_read decodes the state register so a reset drops it immediately.
  assign m_read    = (state_q == ST_READ);
  assign m_address = 2'd0;
  assign readdata  = readdata_q;
  assign sw_en     = sw_q;
  assign irq       = edge_q & ie_q;

endmodule

// File: tb/tb_sw_en_poller.sv
// Bench for sw_en_poller: a poll-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_sw_en_poller;

  localparam int PERIOD_RST = 1000;
  localparam int DEB_N      = 4;

  localparam int M_IDLE = 0;
  localparam int M_WAIT = 1;
  localparam int M_READ = 2;
  localparam int M_EVAL = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [1:0]  m_address;
  logic        m_read;
  logic        m_waitrequest = 1'b0;
  logic [31:0] m_readdata;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic        sw_en;
  logic        irq;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit chk_on = 0;

  // PIO bit pattern, indexed by transfers completed since pbase
  logic [63:0] pat = '1;
  int pidx = 0;
  int pbase = 0;
  logic [5:0] pofs;
  assign pofs = 6'(pidx - pbase);
  assign m_readdata = {31'h2B3C_4D5E, pat[pofs]};

  sw_en_poller #(.PERIOD_RST(PERIOD_RST), .DEB_N(DEB_N)) dut (
    .clk(clk), .reset_n(reset_n),
    .m_address(m_address), .m_read(m_read),
    .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
    .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(readdata),
    .sw_en(sw_en), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // reference model: poll phase, registers, and a queue of samples that
  // disagree with the accepted level since the last agreement
  int ph = M_IDLE;
  int wleft = 0;
  int m_period = PERIOD_RST;
  int m_polls = 0;
  bit m_en = 0, m_ie = 0, m_edge = 0, m_sw = 0, m_sample = 0;
  bit hist_q[$];
  logic [31:0] m_rd = 32'd0;

  task automatic model_reset();
    ph = M_IDLE; wleft = 0; m_period = PERIOD_RST; m_polls = 0;
    m_en = 0; m_ie = 0; m_edge = 0; m_sw = 0; m_sample = 0;
    hist_q.delete();
    m_rd = 32'd0;
  endtask

  task automatic model_step();
    bit eset;
    int nper;
    eset = 0;
    case (address)
      2'd0: m_rd = {30'd0, m_ie, m_en};
      2'd1: m_rd = 32'(m_period);
      2'd2: m_rd = {30'd0, m_edge, m_sw};
      default: m_rd = 32'(m_polls);
    endcase
    nper = (m_period == 0) ? 1 : m_period;
    case (ph)
      M_IDLE: if (m_en) begin ph = M_WAIT; wleft = nper; end
      M_WAIT: begin
        if (!m_en) ph = M_IDLE;
        else begin
          wleft = wleft - 1;
          if (wleft == 0) ph = M_READ;
        end
      end
      M_READ: if (!m_waitrequest) begin
        m_sample = m_readdata[0];
        pidx <= pidx + 1;
        ph = M_EVAL;
      end
      default: begin
        m_polls = (m_polls + 1) % 65536;
        if (m_sample == m_sw) hist_q.delete();
        else begin
          hist_q.push_back(m_sample);
          if (hist_q.size() == DEB_N) begin
            m_sw = m_sample; eset = 1; hist_q.delete();
          end
        end
        if (m_en) begin ph = M_WAIT; wleft = nper; end
        else ph = M_IDLE;
      end
    endcase
    if (chipselect && !write_n) begin
      case (address)
        2'd0: begin m_en = writedata[0]; m_ie = writedata[1]; end
        2'd1: m_period = int'(writedata[15:0]);
        2'd2: if (writedata[1]) m_edge = 0;
        default: ;
      endcase
    end
    if (eset) m_edge = 1;
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else model_step();
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        chk("m_read", 32'(m_read), 32'(ph == M_READ));
        chk("m_address", 32'(m_address), 32'd0);
        chk("sw_en", 32'(sw_en), 32'(m_sw));
        chk("irq", 32'(irq), 32'(m_edge & m_ie));
        chk("readdata", readdata, m_rd);
      end
    end
  end

  // all stimulus tasks are entered and left on a falling edge
  task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
  endtask

  task automatic csr_rd(input logic [1:0] a, input logic [31:0] exp, input string nm);
    address = a;
    @(negedge clk);
    chk(nm, readdata, exp);
  endtask

  task automatic wait_mread(input logic lvl, output int at);
    int n;
    n = 0;
    at = -1;
    while (m_read !== lvl && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (m_read !== lvl) chk("m_read_timeout", 32'(m_read), 32'(lvl));
    else at = cyc;
  endtask

  // returns one edge after EVAL; with clr the STATUS clear hits EVAL's exit edge
  task automatic wait_poll(output int rise, input bit clr);
    int d;
    wait_mread(1'b1, rise);
    wait_mread(1'b0, d);
    if (clr) csr_wr(2'd2, 32'h2);
    else @(negedge clk);
  endtask

  task automatic count_mread(input int n, output int c);
    c = 0;
    for (int k = 0; k < n; k++) begin
      if (m_read === 1'b1) c++;
      @(negedge clk);
    end
  endtask

  task automatic pulse_reset();
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int r[8];
    int c;
    reset_n = 1'b0;
    chk_on = 1;
    @(negedge clk);
    chk("rst_m_read", 32'(m_read), 32'd0);
    chk("rst_readdata", readdata, 32'd0);
    chk("rst_sw_en", 32'(sw_en), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    #2 reset_n = 1'b1;
    @(negedge clk);
    csr_rd(2'd1, 32'd1000, "period_rst");
    csr_rd(2'd0, 32'd0, "ctrl_rst");
    csr_rd(2'd2, 32'd0, "status_rst");
    csr_rd(2'd3, 32'd0, "polls_rst");

    // PERIOD=3, bit0=1: a poll every 5 cycles, level accepted on poll 4
    csr_wr(2'd1, 32'd3);
    csr_wr(2'd0, 32'h1);
    for (int i = 0; i < 4; i++) begin
      wait_poll(r[i], 1'b0);
      if (i == 2) chk("sw_before_4th", 32'(sw_en), 32'd0);
      if (i == 3) chk("sw_after_4th", 32'(sw_en), 32'd1);
    end
    csr_wr(2'd0, 32'h0);
    chk("interval_1", 32'(r[1] - r[0]), 32'd5);
    chk("interval_2", 32'(r[2] - r[1]), 32'd5);
    chk("interval_3", 32'(r[3] - r[2]), 32'd5);
    csr_rd(2'd3, 32'd4, "polls_4");
    csr_rd(2'd2, 32'd3, "status_edge");

    // interrupt enable and write-1-clear
    csr_wr(2'd0, 32'h2);
    chk("irq_on", 32'(irq), 32'd1);
    csr_wr(2'd2, 32'h2);
    chk("irq_cleared", 32'(irq), 32'd0);
    csr_rd(2'd2, 32'd1, "status_after_clr");

    // pattern 1,1,0,1,1,1,1 from sw_en=0; the 7th poll's edge beats a same-cycle clear
    pulse_reset();
    pbase = pidx;
    pat = '1;
    pat[2] = 1'b0;
    csr_wr(2'd1, 32'd3);
    csr_wr(2'd0, 32'h3);
    for (int i = 0; i < 7; i++) begin
      wait_poll(r[i], i == 6);
      if (i < 6) chk("sw_pattern_hold", 32'(sw_en), 32'd0);
    end
    csr_wr(2'd0, 32'h2);
    chk("sw_pattern_7th", 32'(sw_en), 32'd1);
    chk("irq_set_wins", 32'(irq), 32'd1);
    csr_rd(2'd3, 32'd7, "polls_7");
    csr_wr(2'd2, 32'h2);

    // waitrequest held for 10 cycles
    m_waitrequest = 1'b1;
    csr_wr(2'd0, 32'h1);
    wait_mread(1'b1, r[0]);
    c = 0;
    for (int k = 0; k < 11; k++) begin
      if (k == 10) m_waitrequest = 1'b0;
      if (m_read === 1'b1 && m_address === 2'd0) c++;
      @(negedge clk);
    end
    chk("stall_read_cycles", 32'(c), 32'd11);
    chk("stall_read_done", 32'(m_read), 32'd0);
    @(negedge clk);
    csr_wr(2'd0, 32'h0);
    csr_rd(2'd3, 32'd8, "polls_stall");

    // EN cleared while READ is stalled: transfer still completes
    m_waitrequest = 1'b1;
    csr_wr(2'd0, 32'h1);
    wait_mread(1'b1, r[0]);
    csr_wr(2'd0, 32'h0);
    repeat (3) @(negedge clk);
    m_waitrequest = 1'b0;
    wait_mread(1'b0, r[1]);
    count_mread(30, c);
    chk("no_read_after_abort", 32'(c), 32'd0);
    csr_rd(2'd3, 32'd9, "polls_read_abort");

    // EN cleared in WAIT: no transfer
    csr_wr(2'd1, 32'd20);
    csr_wr(2'd0, 32'h1);
    repeat (5) @(negedge clk);
    csr_wr(2'd0, 32'h0);
    count_mread(40, c);
    chk("no_read_wait_abort", 32'(c), 32'd0);
    csr_rd(2'd3, 32'd9, "polls_wait_abort");

    // PERIOD=0 acts as 1; a PERIOD change applies from the next WAIT
    csr_wr(2'd1, 32'd0);
    csr_wr(2'd0, 32'h1);
    for (int i = 0; i < 3; i++) wait_poll(r[i], 1'b0);
    chk("period0_int_1", 32'(r[1] - r[0]), 32'd3);
    chk("period0_int_2", 32'(r[2] - r[1]), 32'd3);
    csr_wr(2'd1, 32'd2);
    for (int i = 3; i < 6; i++) wait_poll(r[i], 1'b0);
    chk("period2_int_1", 32'(r[4] - r[3]), 32'd4);
    chk("period2_int_2", 32'(r[5] - r[4]), 32'd4);
    for (int i = 0; i < 300; i++) wait_poll(r[6], 1'b0);
    csr_wr(2'd0, 32'h0);
    csr_rd(2'd3, 32'd315, "polls_315");

    // reset asserted mid-READ
    m_waitrequest = 1'b1;
    csr_wr(2'd0, 32'h3);
    wait_mread(1'b1, r[0]);
    #2 reset_n = 1'b0;
    #1;
    chk("async_m_read", 32'(m_read), 32'd0);
    chk("async_readdata", readdata, 32'd0);
    chk("async_sw_en", 32'(sw_en), 32'd0);
    chk("async_irq", 32'(irq), 32'd0);
    @(negedge clk);
    m_waitrequest = 1'b0;
    #2 reset_n = 1'b1;
    @(negedge clk);
    csr_rd(2'd0, 32'd0, "ctrl_after_rst");
    csr_rd(2'd1, 32'd1000, "period_after_rst");
    csr_rd(2'd2, 32'd0, "status_after_rst");
    csr_rd(2'd3, 32'd0, "polls_after_rst");
    count_mread(20, c);
    chk("no_read_after_rst", 32'(c), 32'd0);

    chk_on = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
